mux16_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one 16-input resource among 16 requesters by driving the 4-bit select of the datapath's 16:1 multiplexer (`MUX1_16x1` / `MUX32_16x1` family). Each requester raises a request and holds it while it needs the resource. The arbiter grants exactly one requester at a time, bounds each tenure to `MAX_HOLD` cycles, and rotates priority so that no requester starves. Its `SEL` output connects directly to the mux select port; `GNT` goes back to the requesters.

---
 rtl/mux16_rr_arbiter.sv | 103 ++++++++++
 tb/tb_mux16_rr_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter driving the select of a 16:1 datapath mux.
// Tenure is bounded to MAX_HOLD cycles; release hands off with no idle bubble.
module mux16_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] REQ,
  output logic [15:0] GNT,
  output logic [3:0]  SEL,
  output logic        VALID
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_n;
  logic [3:0]  ptr, ptr_n;
  logic [7:0]  cnt, cnt_n;
  logic [15:0] gnt_n;
  logic [3:0]  sel_n;
  logic        valid_n;

  logic        hit_a, hit_b;
  logic [3:0]  pick_a, pick_b;
  logic [3:0]  ptr_rel;
  logic        rel;

  // Scan from high offset down so the lowest offset from p wins.
  function automatic logic [4:0] pick(
    input logic [15:0] r,
    input logic [3:0]  p
  );
    logic [4:0] res;
    logic [3:0] j;
    res = '0;
    for (int k = 15; k >= 0; k--) begin
      j = p + 4'(k);
      if (r[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  assign ptr_rel        = SEL + 4'd1;
  assign {hit_a, pick_a} = pick(REQ, ptr);
  assign {hit_b, pick_b} = pick(REQ, ptr_rel);
  assign rel = !REQ[SEL] || (cnt == 8'(MAX_HOLD - 1));

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    gnt_n   = GNT;
    sel_n   = SEL;
    valid_n = VALID;
    unique case (state)
      IDLE: begin
        if (hit_a) begin
          state_n = BUSY;
          gnt_n   = 16'd1 << pick_a;
          sel_n   = pick_a;
          valid_n = 1'b1;
          cnt_n   = '0;
        end
      end
      BUSY: begin
        if (!rel) begin
          cnt_n = cnt + 8'd1;
        end else begin
          ptr_n = ptr_rel;
          cnt_n = '0;
          if (hit_b) begin
            gnt_n = 16'd1 << pick_b;
            sel_n = pick_b;
          end else begin
            state_n = IDLE;
            gnt_n   = '0;
            valid_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      ptr   <= '0;
      cnt   <= '0;
      GNT   <= '0;
      SEL   <= '0;
      VALID <= 1'b0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      cnt   <= cnt_n;
      GNT   <= gnt_n;
      SEL   <= sel_n;
      VALID <= valid_n;
    end
  end

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Scoreboard bench for mux16_rr_arbiter at MAX_HOLD = 8, 2 and 4.
// Stimulus pushes hand-computed expectations; a negedge monitor compares.
module tb_mux16_rr_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [15:0] req8 = '0, req2 = '0, req4 = '0;
  logic [15:0] g8, g2, g4;
  logic [3:0]  s8, s2, s4;
  logic        v8, v2, v4;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    string       name;
    logic [15:0] gnt;
    logic [3:0]  sel;
    logic        valid;
    int          ptr;
    int          cnt;
  } exp_t;

  exp_t sb[$];

  always #5 CLK = ~CLK;

  mux16_rr_arbiter #(.MAX_HOLD(8)) u8 (
    .CLK(CLK), .RST(RST), .REQ(req8), .GNT(g8), .SEL(s8), .VALID(v8)
  );
  mux16_rr_arbiter #(.MAX_HOLD(2)) u2 (
    .CLK(CLK), .RST(RST), .REQ(req2), .GNT(g2), .SEL(s2), .VALID(v2)
  );
  mux16_rr_arbiter #(.MAX_HOLD(4)) u4 (
    .CLK(CLK), .RST(RST), .REQ(req4), .GNT(g4), .SEL(s4), .VALID(v4)
  );

  task automatic check(input exp_t e);
    logic [15:0] ag;
    logic [3:0]  as, ap;
    logic        av;
    logic [7:0]  ac;
    case (e.id)
      0: begin ag = g8; as = s8; av = v8; ap = u8.ptr; ac = u8.cnt; end
      1: begin ag = g2; as = s2; av = v2; ap = u2.ptr; ac = u2.cnt; end
      default: begin
        ag = g4; as = s4; av = v4; ap = u4.ptr; ac = u4.cnt;
      end
    endcase
    checks++;
    if ({ag, as, av} !== {e.gnt, e.sel, e.valid}) begin
      errors++;
      $display("FAIL %s: got gnt=%h sel=%0d valid=%b, want gnt=%h sel=%0d valid=%b",
               e.name, ag, as, av, e.gnt, e.sel, e.valid);
    end
    if (e.ptr >= 0) begin
      checks++;
      if (ap !== 4'(e.ptr)) begin
        errors++;
        $display("FAIL %s_ptr: got %0d, want %0d", e.name, ap, e.ptr);
      end
    end
    if (e.cnt >= 0) begin
      checks++;
      if (ac !== 8'(e.cnt)) begin
        errors++;
        $display("FAIL %s_cnt: got %0d, want %0d", e.name, ac, e.cnt);
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      while (sb.size() > 0) check(sb.pop_front());
    end
  end

  // Drive one cycle; expectation applies right after the coming edge.
  task automatic st(
    input int          id,
    input logic        rst,
    input logic [15:0] req,
    input string       nm,
    input logic [15:0] g,
    input int          s,
    input int          p,
    input int          c
  );
    exp_t e;
    RST = rst;
    case (id)
      0:       req8 = req;
      1:       req2 = req;
      default: req4 = req;
    endcase
    @(posedge CLK);
    e.id = id; e.name = nm; e.gnt = g; e.sel = 4'(s);
    e.valid = |g; e.ptr = p; e.cnt = c;
    sb.push_back(e);
    #1;
  endtask

  initial begin
    st(0, 0, 16'hFFFF, "rst0", 16'h0, 0, 0, 0);
    st(0, 0, 16'hFFFF, "rst1", 16'h0, 0, 0, 0);
    st(0, 1, 16'h0000, "idle0", 16'h0, 0, 0, -1);
    st(0, 1, 16'h0000, "idle1", 16'h0, 0, 0, -1);

    for (int i = 0; i < 3; i++)
      st(0, 1, 16'h0008, "single", 16'h0008, 3, 0, i);
    st(0, 1, 16'h0000, "single_rel", 16'h0, 3, 4, -1);
    st(0, 1, 16'h0000, "sel_hold", 16'h0, 3, 4, -1);
    st(0, 1, 16'h0001, "req0", 16'h0001, 0, 4, 0);
    st(0, 1, 16'h0000, "req0_rel", 16'h0, 0, 1, -1);

    for (int k = 0; k < 34; k++)
      st(1, 1, 16'hFFFF, "rotate", 16'd1 << ((k / 2) % 16),
         (k / 2) % 16, -1, k % 2);
    st(1, 1, 16'h0000, "rot_rel", 16'h0, 0, 1, -1);

    for (int k = 0; k < 10; k++)
      st(2, 1, 16'h0400, "timeout", 16'h0400, 10,
         (k < 4) ? 0 : 11, k % 4);
    st(2, 1, 16'h0000, "to_rel", 16'h0, 10, 11, -1);

    st(0, 0, 16'h0000, "rst_f", 16'h0, 0, 0, 0);
    st(0, 1, 16'h0020, "own5", 16'h0020, 5, 0, 0);
    st(0, 1, 16'h8021, "own5_hold", 16'h0020, 5, 0, 1);
    st(0, 1, 16'h8001, "to15", 16'h8000, 15, 6, 0);
    st(0, 1, 16'h0001, "to0", 16'h0001, 0, 0, 0);
    st(0, 1, 16'h0000, "fair_rel", 16'h0, 0, 1, -1);

    st(0, 1, 16'h0080, "own7", 16'h0080, 7, 1, 0);
    st(0, 1, 16'h0080, "own7", 16'h0080, 7, 1, 1);
    st(0, 1, 16'h0080, "own7_c2", 16'h0080, 7, 1, 2);
    st(0, 0, 16'h0080, "rst_mid", 16'h0, 0, 0, 0);
    st(0, 1, 16'h0081, "after_rst", 16'h0001, 0, 0, 0);

    @(negedge CLK);
    @(negedge CLK);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
